dac_out_ctrl: RTL and testbench

- Output-side counterpart to the ADC capture path: it formats filter results for the HSMC DAC pins HSMC_DA and HSMC_DB.
- Channel A carries the corrected gamma signal. Channel B carries a second 16-bit stream, e.g. the raw mic signal.
- Functions: saturating 16→14-bit narrowing, a click-free fade-in/fade-out mute on channel A, built-in test patterns, and two's-complement/offset-binary formatting.
- Sits between micFilter output and the board DAC. Runs entirely in the system clock domain.

---
 rtl/dac_pkg.sv | 32 +++
 rtl/dac_sat14.sv | 21 ++
 rtl/dac_out_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dac_out_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the HSMC DAC output path: state/mode encodings,
// code-space constants and the output code formatter.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_MUTED    = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_RUN      = 2'd2,
        ST_FADE_OUT = 2'd3
    } fade_state_e;

    typedef enum logic [1:0] {
        MODE_DATA   = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_CONST  = 2'd3
    } mode_e;

    localparam int                        DAC_W    = 14;
    localparam logic signed [DAC_W-1:0]   DAC_MAX  = 14'sh1FFF;
    localparam logic signed [DAC_W-1:0]   DAC_MIN  = 14'sh2000;
    localparam logic [8:0]                GAIN_ONE = 9'd256;
    localparam logic signed [DAC_W-1:0]   SQ_AMP   = 14'sd4096;
    localparam int                        SQ_HALF  = 64;

    // Offset binary is two's complement with the sign bit flipped.
    function automatic logic [DAC_W-1:0] to_code(input logic signed [DAC_W-1:0] v,
                                                 input logic offset_bin);
        return offset_bin ? {~v[DAC_W-1], v[DAC_W-2:0]} : v;
    endfunction

endpackage

// File: rtl/dac_sat14.sv
// Combinational 16-bit to 14-bit signed saturator; sat flags a clipped sample.
module dac_sat14
    import dac_pkg::*;
(
    input  logic signed [15:0]      din,
    output logic signed [DAC_W-1:0] dout,
    output logic                    sat
);

    always_comb begin
        // Out of range exactly when the top three bits disagree with the sign.
        sat = (din[15:13] != {3{din[15]}});
        if (!sat)
            dout = din[13:0];
        else if (din[15])
            dout = DAC_MIN;
        else
            dout = DAC_MAX;
    end

endmodule

// File: rtl/dac_out_ctrl.sv
// HSMC DAC output controller: source select and saturation, click-free fade
// on channel A, delay-matched channel B and output code formatting.
module dac_out_ctrl
    import dac_pkg::*;
#(
    parameter int FADE_DIV  = 1,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          din_a,
    input  logic [15:0]          din_b,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DAC_W-1:0]     const_val,
    input  logic                 offset_bin,
    input  logic                 sat_clr,
    output logic [DAC_W-1:0]     HSMC_DA,
    output logic [DAC_W-1:0]     HSMC_DB,
    output logic                 muted,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    localparam int               PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

    fade_state_e             state_q, state_d;
    logic [8:0]              gain_q, gain_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic                    step;

    logic signed [DAC_W-1:0] saw_q;
    logic [5:0]              sq_cnt_q;
    logic                    sq_phase_q;

    logic signed [15:0]      src_a;
    logic signed [DAC_W-1:0] sat_a, sat_b;
    logic                    sat_a_flag, sat_b_flag, sat_event;
    logic signed [DAC_W-1:0] s1_a, s1_b, s2_a, s2_b;
    logic signed [22:0]      a_ext, g_ext, prod_a;

    // ---------------- gain FSM ----------------
    assign step = (pre_q == PRE_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        gain_d  = gain_q;
        pre_d   = pre_q;
        case (state_q)
            ST_MUTED: begin
                gain_d = '0;
                if (en) begin
                    state_d = ST_FADE_IN;
                    pre_d   = '0;
                end
            end
            ST_FADE_IN: begin
                if (!en) begin
                    state_d = ST_FADE_OUT;
                    pre_d   = '0;
                end else if (step) begin
                    pre_d  = '0;
                    gain_d = gain_q + 9'd1;
                    if (gain_q == GAIN_ONE - 9'd1)
                        state_d = ST_RUN;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            ST_RUN: begin
                gain_d = GAIN_ONE;
                if (!en) begin
                    state_d = ST_FADE_OUT;
                    pre_d   = '0;
                end
            end
            ST_FADE_OUT: begin
                if (en) begin
                    state_d = ST_FADE_IN;
                    pre_d   = '0;
                end else if (step) begin
                    pre_d  = '0;
                    gain_d = gain_q - 9'd1;
                    if (gain_q == 9'd1)
                        state_d = ST_MUTED;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: begin
                state_d = ST_MUTED;
                gain_d  = '0;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_MUTED;
            gain_q  <= '0;
            pre_q   <= '0;
            muted   <= 1'b1;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            pre_q   <= pre_d;
            muted   <= (state_d == ST_MUTED);
        end
    end

    // ---------------- free-running test patterns ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saw_q      <= '0;
            sq_cnt_q   <= '0;
            sq_phase_q <= 1'b0;
        end else begin
            saw_q    <= saw_q + 14'sd1;
            sq_cnt_q <= sq_cnt_q + 6'd1;
            if (sq_cnt_q == 6'(SQ_HALF - 1))
                sq_phase_q <= ~sq_phase_q;
        end
    end

    // ---------------- S1: source select and saturation ----------------
    always_comb begin
        src_a = din_a;
        case (mode_e'(mode))
            MODE_SAW:    src_a = {{2{saw_q[DAC_W-1]}}, saw_q};
            MODE_SQUARE: src_a = sq_phase_q ? -16'sd4096 : {{2{SQ_AMP[DAC_W-1]}}, SQ_AMP};
            MODE_CONST:  src_a = {{2{const_val[DAC_W-1]}}, const_val};
            default:     src_a = din_a;
        endcase
    end

    dac_sat14 u_sat_a (.din(src_a),          .dout(sat_a), .sat(sat_a_flag));
    dac_sat14 u_sat_b (.din($signed(din_b)), .dout(sat_b), .sat(sat_b_flag));

    // Pattern sources never clip, so only live data on A is worth counting.
    assign sat_event = (sat_a_flag && (mode == MODE_DATA)) || sat_b_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (sat_event && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + SAT_CNT_W'(1);
        end
    end

    // ---------------- S2: gain, S3: format ----------------
    assign a_ext  = {{9{s1_a[DAC_W-1]}}, s1_a};
    assign g_ext  = {14'd0, gain_q};
    assign prod_a = a_ext * g_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s2_a    <= '0;
            s2_b    <= '0;
            HSMC_DA <= '0;
            HSMC_DB <= '0;
        end else begin
            s1_a    <= sat_a;
            s1_b    <= sat_b;
            // Arithmetic shift floors; gain 256 reproduces the sample exactly.
            s2_a    <= 14'(prod_a >>> 8);
            s2_b    <= s1_b;
            HSMC_DA <= to_code(s2_a, offset_bin);
            HSMC_DB <= to_code(s2_b, offset_bin);
        end
    end

endmodule

// File: tb/tb_dac_out_ctrl.sv
// Self-checking bench for dac_out_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of fades, patterns and the pipeline.
module tb_dac_out_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din_a, din_b;
    logic        en;
    logic [1:0]  mode;
    logic [13:0] const_val;
    logic        offset_bin, sat_clr;
    logic [13:0] HSMC_DA, HSMC_DB;
    logic        muted;
    logic [15:0] sat_cnt;

    dac_out_ctrl #(.FADE_DIV(1), .SAT_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .en(en), .mode(mode),
        .const_val(const_val), .offset_bin(offset_bin), .sat_clr(sat_clr),
        .HSMC_DA(HSMC_DA), .HSMC_DB(HSMC_DB), .muted(muted), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: gain moves one step per clk toward 256 (en=1) or 0 (en=0);
    // a change of direction costs one clk with the gain held.
    int m_gain, m_cnt, cyc;
    bit m_up;
    int src_h [16384];
    int b_h   [16384];
    int g_h   [16384];
    bit ob_h  [16384];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp14(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    function automatic int wrap14(input int v);
        int r;
        r = ((v % 16384) + 16384) % 16384;
        return (r >= 8192) ? r - 16384 : r;
    endfunction

    function automatic int code(input int v, input bit ob);
        int c;
        c = v & 32'h3FFF;
        if (ob) c = c ^ 32'h2000;
        return c;
    endfunction

    function automatic int src_model();
        case (mode)
            2'd0:    return clamp14(int'($signed(din_a)));
            2'd1:    return wrap14(cyc);
            2'd2:    return (((cyc / 64) % 2) == 0) ? 4096 : -4096;
            default: return int'($signed(const_val));
        endcase
    endfunction

    task automatic tick();
        int n, ea, eb, sa, sb;
        bit sat_any;
        sa = int'($signed(din_a));
        sb = int'($signed(din_b));
        sat_any = ((mode == 2'd0) && (clamp14(sa) != sa)) || (clamp14(sb) != sb);
        src_h[cyc] = src_model();
        b_h[cyc]   = clamp14(sb);
        g_h[cyc]   = m_gain;
        ob_h[cyc]  = offset_bin;
        @(posedge clk);
        if (sat_clr) m_cnt = 0;
        else if (sat_any && m_cnt < 65535) m_cnt++;
        if (en != m_up) m_up = en;
        else if (m_up && m_gain < 256) m_gain++;
        else if (!m_up && m_gain > 0) m_gain--;
        n = cyc;
        cyc++;
        ea = (n >= 2) ? ((src_h[n-2] * g_h[n-1]) >>> 8) : 0;
        eb = (n >= 2) ? b_h[n-2] : 0;
        #1;
        check("da", HSMC_DA, code(ea, ob_h[n]));
        check("db", HSMC_DB, code(eb, ob_h[n]));
        check("muted", muted, (!m_up && m_gain == 0));
        check("sat_cnt", sat_cnt, m_cnt);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic model_reset();
        cyc = 0; m_gain = 0; m_up = 0; m_cnt = 0;
    endtask

    initial begin
        logic [13:0] prev;
        rst = 1'b1; din_a = 16'd1000; din_b = 16'd500; en = 1'b0; mode = 2'd0;
        const_val = '0; offset_bin = 1'b0; sat_clr = 1'b0;
        model_reset();
        #22;
        check("rst_da", HSMC_DA, 0);
        check("rst_db", HSMC_DB, 0);
        check("rst_muted", muted, 1);
        check("rst_sat_cnt", sat_cnt, 0);
        rst = 1'b0;

        // Muted: data never reaches the pins.
        ticks(10);
        check("mute_da", HSMC_DA, 0);

        // Fade in to RUN with a full-scale-ish sample.
        en = 1'b1; din_a = 16'd8000;
        tick();
        check("muted_fall", muted, 0);
        ticks(269);
        check("ramp_end", HSMC_DA, 8000);

        // Saturation on both channels, then clear colliding with saturation.
        din_a = 16'd20000; din_b = 16'hB1E0;
        ticks(5);
        check("sat_da", HSMC_DA, 14'h1FFF);
        check("sat_db", HSMC_DB, 14'h2000);
        check("sat_cnt5", sat_cnt, 5);
        sat_clr = 1'b1;
        tick();
        check("sat_clr_wins", sat_cnt, 0);
        sat_clr = 1'b0; din_a = 16'd0; din_b = 16'd0;
        ticks(3);

        // Offset-binary formatting.
        offset_bin = 1'b1;
        ticks(3);
        check("ob_zero", HSMC_DA, 14'h2000);
        din_a = 16'hE000;
        ticks(3);
        check("ob_min", HSMC_DA, 14'h0000);
        offset_bin = 1'b0;

        // Run random data until the sawtooth nears its wrap point.
        while ((cyc % 16384) != 8170) begin
            din_a = 16'($urandom); din_b = 16'($urandom_range(0, 4000));
            tick();
        end
        mode = 2'd1;
        prev = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i >= 3) begin
                check("saw_step", HSMC_DA, (prev + 14'd1));
                if (prev == 14'h1FFF) check("saw_wrap", HSMC_DA, 14'h2000);
            end
            prev = HSMC_DA;
        end

        mode = 2'd3; const_val = 14'h3FFB;
        ticks(3);
        check("const_neg5", HSMC_DA, 14'h3FFB);

        // Fade in interrupted at gain 100, then fade out to mute.
        mode = 2'd0; din_a = 16'd8000; en = 1'b0;
        ticks(262);
        check("muted_again", muted, 1);
        en = 1'b1;
        ticks(101);
        en = 1'b0;
        ticks(100);
        check("fade_out_not_yet", muted, 0);
        tick();
        check("fade_out_done", muted, 1);

        // Random traffic across all modes, formats and fade directions.
        for (int i = 0; i < 1500; i++) begin
            din_a = 16'($urandom);
            din_b = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 8191));
            mode = 2'($urandom_range(0, 3));
            const_val = 14'($urandom);
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 31) == 0) offset_bin = ~offset_bin;
            sat_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        // Asynchronous reset in the middle of a fade-in.
        mode = 2'd0; din_a = 16'd8000; din_b = 16'd100; offset_bin = 1'b0; sat_clr = 1'b0;
        en = 1'b0;
        ticks(262);
        en = 1'b1;
        ticks(50);
        check("pre_rst_live", (HSMC_DA != 0), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_da", HSMC_DA, 0);
        check("midrst_muted", muted, 1);
        check("midrst_sat_cnt", sat_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        ticks(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
